// File: rtl/ff_bist_ctrl.sv
// ff_bist_ctrl: self-test sequencer and checker for a bank of async-reset D flip-flops
module ff_bist_ctrl #(
    parameter int WIDTH = 8,
    parameter int ERRW = 8,
    localparam int IDXW = $clog2(2 * WIDTH + 3)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERRW-1:0]  ERR_CNT,
    output logic [IDXW-1:0]  FIRST_FAIL,
    output logic [WIDTH-1:0] FF_D,
    output logic             FF_RST_N,
    input  logic [WIDTH-1:0] FF_Q
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    localparam logic [IDXW-1:0] LAST = IDXW'(2 * WIDTH + 2);
    state_t state;
    logic [IDXW-1:0] k, nk, idx;
    logic [WIDTH-1:0] exp_q;
    logic vld;
    function automatic logic [WIDTH-1:0] pat(input logic [IDXW-1:0] n);
        int i;
        i = int'(n);
        return i == 0 ? '0 : i < 3 ? '1 : i < 3 + WIDTH ? WIDTH'(1) << (i - 3) : ~(WIDTH'(1) << (i - 3 - WIDTH));
    endfunction
    assign nk = k + IDXW'(1);
    // the only pattern whose expectation differs from its D value is the reset check, the one cycle FF_RST_N is low
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            k <= '0;
            idx <= '0;
            exp_q <= '0;
            vld <= 1'b0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            PASS <= 1'b0;
            ERR_CNT <= '0;
            FIRST_FAIL <= '0;
            FF_D <= '0;
            FF_RST_N <= 1'b0;
        end else begin
            exp_q <= FF_D & {WIDTH{FF_RST_N}};
            vld <= state == RUN;
            idx <= k;
            DONE <= 1'b0;
            FF_RST_N <= 1'b1;
            if (vld && FF_Q != exp_q) begin
                ERR_CNT <= &ERR_CNT ? ERR_CNT : ERR_CNT + ERRW'(1);
                if (ERR_CNT == '0) FIRST_FAIL <= idx;
            end
            case (state)
                IDLE: if (START) begin
                    state <= RUN;
                    BUSY <= 1'b1;
                    PASS <= 1'b0;
                    ERR_CNT <= '0;
                    FIRST_FAIL <= '0;
                    k <= '0;
                    FF_D <= '0;
                end
                RUN: if (k == LAST) begin
                    state <= DRAIN;
                    FF_D <= '0;
                end else begin
                    k <= nk;
                    FF_D <= pat(nk);
                    FF_RST_N <= nk != IDXW'(2);
                end
                DRAIN: state <= FIN;
                FIN: begin
                    state <= IDLE;
                    BUSY <= 1'b0;
                    DONE <= 1'b1;
                    PASS <= ERR_CNT == '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ff_bist_ctrl.sv
// tb_ff_bist_ctrl: checks two ff_bist_ctrl instances (ERRW 8 and 3) against faulty and healthy bank models
module tb_ff_bist_ctrl;
    localparam int W = 8;
    localparam int NP = 2 * W + 3;
    logic CLK = 1'b0, RST = 1'b1, START = 1'b0;
    logic busy8, done8, pass8, rstn8, busy3, done3, pass3, rstn3;
    logic [7:0] err8;
    logic [2:0] err3;
    logic [4:0] ff8, ff3;
    logic [W-1:0] d8, d3, q8, q3, bank8, bank3;
    logic [W-1:0] s0 = '0, s1 = '0;
    logic ign = 1'b0;
    logic [W-1:0] pats [0:NP-1];
    logic [W-1:0] ex [0:NP-1];
    int n_chk = 0, n_fail = 0;
    typedef struct {
        string nm;
        logic [W-1:0] m0, m1;
        logic ig;
        int cnt, first;
    } vec_t;
    vec_t vt [6];

    ff_bist_ctrl #(.WIDTH(W), .ERRW(8)) dut8 (.CLK(CLK), .RST(RST), .START(START), .BUSY(busy8), .DONE(done8),
        .PASS(pass8), .ERR_CNT(err8), .FIRST_FAIL(ff8), .FF_D(d8), .FF_RST_N(rstn8), .FF_Q(q8));
    ff_bist_ctrl #(.WIDTH(W), .ERRW(3)) dut3 (.CLK(CLK), .RST(RST), .START(START), .BUSY(busy3), .DONE(done3),
        .PASS(pass3), .ERR_CNT(err3), .FIRST_FAIL(ff3), .FF_D(d3), .FF_RST_N(rstn3), .FF_Q(q3));

    always #5 CLK = ~CLK;
    // bank cells: reset low at the capture edge forces 0 unless the fault ignores reset; stuck masks on Q
    always @(posedge CLK) bank8 <= (rstn8 || ign) ? d8 : '0;
    always @(posedge CLK) bank3 <= (rstn3 || ign) ? d3 : '0;
    assign q8 = (bank8 & ~s0) | s1;
    assign q3 = (bank3 & ~s0) | s1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] m0, input logic [W-1:0] m1, input logic ig,
                                  output int cnt, output int first);
        logic [W-1:0] seen;
        cnt = 0;
        first = 0;
        for (int k = 0; k < NP; k++) begin
            seen = (k == 2 && !ig) ? '0 : pats[k];
            seen = (seen & ~m0) | m1;
            if (seen != ex[k]) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
    endfunction

    task automatic run(input string nm, input logic [W-1:0] m0, input logic [W-1:0] m1, input logic ig,
                       input int cnt, input int first, input int pulse_n, input bit chain, input bit again);
        int sat3;
        sat3 = cnt > 7 ? 7 : cnt;
        if (!chain) @(negedge CLK);
        s0 = m0;
        s1 = m1;
        ign = ig;
        START = 1'b1;
        @(posedge CLK);
        for (int n = 0; n <= 21; n++) begin
            @(negedge CLK);
            if (n == 0 || n == pulse_n) START = 1'b0;
            if (n == pulse_n - 1) START = 1'b1;
            chk($sformatf("%s busy@%0d", nm, n), 32'(busy8), 32'(n < 21));
            chk($sformatf("%s done@%0d", nm, n), 32'(done8), 32'(n == 21));
            chk($sformatf("%s done3@%0d", nm, n), 32'(done3), 32'(n == 21));
            chk($sformatf("%s rst_n@%0d", nm, n), 32'(rstn8), 32'(n != 2));
            if (n <= 19) chk($sformatf("%s ff_d@%0d", nm, n), 32'(d8), 32'(n <= 18 ? pats[n] : '0));
        end
        chk({nm, " pass"}, 32'(pass8), 32'(cnt == 0));
        chk({nm, " err"}, 32'(err8), 32'(cnt));
        chk({nm, " first"}, 32'(ff8), 32'(first));
        chk({nm, " pass3"}, 32'(pass3), 32'(cnt == 0));
        chk({nm, " err3"}, 32'(err3), 32'(sat3));
        chk({nm, " first3"}, 32'(ff3), 32'(first));
        if (again) START = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] m0, m1;
        logic ig;
        int cnt, first;
        pats[0] = '0;
        pats[1] = '1;
        pats[2] = '1;
        for (int b = 0; b < W; b++) begin
            pats[3 + b] = '0;
            pats[3 + b][b] = 1'b1;
            pats[3 + W + b] = '1;
            pats[3 + W + b][b] = 1'b0;
        end
        for (int k = 0; k < NP; k++) ex[k] = k == 2 ? '0 : pats[k];
        vt[0] = '{"healthy", 8'h00, 8'h00, 1'b0, 0, 0};
        vt[1] = '{"bit3_sa0", 8'h08, 8'h00, 1'b0, 9, 1};
        vt[2] = '{"rst_ignored", 8'h00, 8'h00, 1'b1, 1, 2};
        vt[3] = '{"all_sa1", 8'h00, 8'hff, 1'b0, 18, 0};
        vt[4] = '{"bit0_sa1", 8'h00, 8'h01, 1'b0, 10, 0};
        vt[5] = '{"all_sa0", 8'hff, 8'h00, 1'b0, 17, 1};

        START = 1'b1;
        repeat (4) @(negedge CLK);
        chk("reset busy", 32'(busy8), 32'(0));
        chk("reset done", 32'(done8), 32'(0));
        chk("reset pass", 32'(pass8), 32'(0));
        chk("reset err", 32'(err8), 32'(0));
        chk("reset first", 32'(ff8), 32'(0));
        chk("reset ff_d", 32'(d8), 32'(0));
        chk("reset rst_n", 32'(rstn8), 32'(0));
        RST = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        chk("post-reset rst_n", 32'(rstn8), 32'(1));
        chk("post-reset busy", 32'(busy8), 32'(0));

        foreach (vt[i]) run(vt[i].nm, vt[i].m0, vt[i].m1, vt[i].ig, vt[i].cnt, vt[i].first, -1, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        chk("hold pass", 32'(pass8), 32'(0));
        chk("hold err", 32'(err8), 32'(17));
        chk("hold first", 32'(ff8), 32'(1));

        run("start_ignored", '0, '0, 1'b0, 0, 0, 5, 1'b0, 1'b1);
        run("back_to_back", 8'h08, '0, 1'b0, 9, 1, -1, 1'b1, 1'b0);

        // reset lands mid-run with errors already counted
        @(negedge CLK);
        s0 = '0;
        s1 = '1;
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst busy", 32'(busy8), 32'(0));
        chk("midrst rst_n", 32'(rstn8), 32'(0));
        chk("midrst err", 32'(err8), 32'(0));
        chk("midrst err3", 32'(err3), 32'(0));
        chk("midrst done", 32'(done8), 32'(0));
        chk("midrst ff_d", 32'(d8), 32'(0));
        RST = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            if (i == 0) chk("midrst release rst_n", 32'(rstn8), 32'(1));
            chk($sformatf("midrst no_done@%0d", i), 32'(done8), 32'(0));
        end
        run("after_rst", '0, '0, 1'b0, 0, 0, -1, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            m0 = W'($urandom & $urandom & $urandom);
            m1 = W'($urandom & $urandom & $urandom) & ~m0;
            ig = 1'($urandom_range(0, 1));
            if (r % 3 == 0) begin
                m0 = '0;
                m1 = '0;
            end
            model(m0, m1, ig, cnt, first);
            run($sformatf("rand%0d", r), m0, m1, ig, cnt, first, -1, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ff_bist_ctrl.md
Name: ff_bist_ctrl

Overview:
- Built-in self-test controller for a bank of WIDTH asynchronous-reset D flip-flops: an array of the team's DFF-with-active-low-async-reset cells sharing one clock.
- Sequences fixed test patterns into the bank's D inputs and drives the bank's reset.
- Compares the bank's Q outputs against expected values and reports pass/fail, error count and first failing pattern.
- Sits beside the flip-flop bank in the FF test harness; the bank is clocked by the same CLK.

Parameters:
- WIDTH, 8, number of flip-flops in the bank under test (≥2).
- ERRW, 8, width of the saturating error counter.
- IDXW, $clog2(2*WIDTH+3), derived localparam, pattern index width; not overridable.

Ports:
- CLK  in  1  clock; rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin test; sampled only in IDLE.
- BUSY  out  1  test in progress.
- DONE  out  1  one-cycle pulse at test end.
- PASS  out  1  result of last completed test; 1 = no errors.
- ERR_CNT  out  ERRW  mismatching patterns, saturating.
- FIRST_FAIL  out  IDXW  index of first mismatching pattern; valid when DONE seen and PASS=0.
- FF_D  out  WIDTH  drives bank D inputs.
- FF_RST_N  out  1  drives bank async reset, active-low.
- FF_Q  in  WIDTH  bank Q outputs.

Behaviour:
- All outputs are registered.

Reset (RST=1 at an edge):
- BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_FAIL=0, FF_D=0, FF_RST_N=0. The bank is held in reset while RST is high.
- FSM goes to IDLE; compare pipeline is cleared.
- RST overrides START and any in-progress test: no DONE, results are cleared.
- First edge after RST falls: FF_RST_N=1.

States: IDLE → RUN → DRAIN → FIN → IDLE.
- IDLE: START=1 at edge E0 → BUSY=1, ERR_CNT=0, FIRST_FAIL=0, PASS=0, pattern index k=0, FF_D=pattern 0; go to RUN.
- RUN: one pattern per cycle; the pattern with index k is driven at edge E0+k, for k=0..2*WIDTH+2.

Pattern table:
- k=0: ALL0. FF_D=0, expect 0.
- k=1: ALL1. FF_D=all ones, expect all ones.
- k=2: RSTCHK. FF_D stays all ones, FF_RST_N=0 for exactly this one cycle, expect 0. This proves async reset dominates D.
- k=3..3+WIDTH-1: WALK1. Only bit (k-3) set.
- k=3+WIDTH..3+2*WIDTH-1: WALK0. Only bit (k-3-WIDTH) clear.
- FF_RST_N=1 for every k≠2.

Compare pipeline:
- At each edge: EXP<=expected value of the pattern currently on FF_D; VLD<=1 if in RUN; IDX<=k.
- At the following edge, if VLD and FF_Q≠EXP: ERR_CNT increments, saturating at 2^ERRW-1. If this is the first mismatch of the run, FIRST_FAIL<=IDX.
- Each pattern is therefore checked 2 edges after it is driven.

Sequence end:
- After the last pattern, RUN → DRAIN for 1 cycle. FF_D=0, no new VLD; the final compare happens here.
- DRAIN → FIN: PASS<=(ERR_CNT==0 after final compare), DONE=1, BUSY=0 → IDLE.
- DONE is high for exactly one cycle, beginning at edge E0+2*WIDTH+5. For WIDTH=8 that is E0+21.
- DONE and BUSY are never high together.

Result holding and START:
- PASS, ERR_CNT and FIRST_FAIL hold until the next START or RST.
- START while BUSY is ignored.
- START in IDLE in the same cycle DONE is high is accepted (back-to-back runs).

Test Plan:
- Healthy 8-bit DFF bank, START at E0: BUSY rises at E0. FF_RST_N low only in cycle E0+2. DONE at E0+21. PASS=1, ERR_CNT=0.
- Bank bit 3 stuck-at-0: fails at ALL1, WALK1 bit 3, and 7 WALK0 patterns. ERR_CNT=9, FIRST_FAIL=1, PASS=0.
- Bank whose reset is ignored (Q keeps all ones): only RSTCHK fails. ERR_CNT=1, FIRST_FAIL=2, PASS=0.
- All bits stuck-at-1, ERRW=3: 18 raw mismatches. ERR_CNT saturates at 7, FIRST_FAIL=0, PASS=0.
- RST at E0+10 mid-run: next cycle BUSY=0, FF_RST_N=0, ERR_CNT=0, no DONE. Later START gives a full run with DONE at the new E0+21.
- START pulsed at E0+5 while BUSY: ignored, DONE still at E0+21. START at the DONE cycle: second run starts; its DONE is 21 edges later.
